// File: rtl/rs_issue_sched_pkg.sv
// Shared types, sizing constants and selection helpers for the issue scheduler.
// Build option: ISSUE_SCHED_RR_EN selects round-robin arbitration in
// rs_issue_sched (fixed lowest-index priority when undefined).
package rs_issue_sched_pkg;

    localparam int RS_SIZE   = 16;
    localparam int MULT_LAT  = 4;
    localparam int BR_MASK_W = 4;
    localparam int RS_IDX_W  = $clog2(RS_SIZE);

    typedef logic [BR_MASK_W-1:0] BRANCH_MASK;
    typedef logic [RS_IDX_W-1:0]  RS_IDX;
    typedef logic [RS_SIZE-1:0]   rs_vec_t;

    // Pick the first set request at or above 'start', wrapping to index 0.
    function automatic rs_vec_t pselect(input rs_vec_t req, input RS_IDX start);
        rs_vec_t gnt;
        logic    found;
        int      pos;
        gnt   = {RS_SIZE{1'b0}};
        found = 1'b0;
        for (int k = 0; k < RS_SIZE; k++) begin
            pos = int'(start) + k;
            if (pos >= RS_SIZE) begin
                pos = pos - RS_SIZE;
            end else begin
                pos = pos;
            end
            if (!found && req[RS_IDX'(pos)]) begin
                gnt[RS_IDX'(pos)] = 1'b1;
                found             = 1'b1;
            end else begin
                found = found;
            end
        end
        return gnt;
    endfunction

    // Encode a one-hot (or zero) vector into its binary index; zero maps to 0.
    function automatic RS_IDX onehot_to_binary(input rs_vec_t oh);
        RS_IDX idx;
        idx = {RS_IDX_W{1'b0}};
        for (int i = 0; i < RS_SIZE; i++) begin
            if (oh[RS_IDX'(i)]) begin
                idx = idx | RS_IDX'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rs_issue_sched_cdb_slot_tracker.sv
// CDB slot tracker: remembers which future CDB cycles are already owned by
// in-flight multiplies, together with the branch mask of each owner.
// Bit k of rsv means the CDB k+1 cycles from now is claimed.
module cdb_slot_tracker
    import rs_issue_sched_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                claim_en,
    input  BRANCH_MASK          claim_mask,
    input  logic                squash_en,
    input  BRANCH_MASK          squash_mask,
    input  logic                resolve_en,
    input  BRANCH_MASK          resolve_mask,
    output logic [MULT_LAT-1:0] rsv,
    output logic                rsv_first,
    output logic                rsv_last
);

    logic [MULT_LAT-1:0]                rsv_r;
    logic [MULT_LAT-1:0]                rsv_s;
    logic [MULT_LAT-1:0][BR_MASK_W-1:0] mask_r;
    logic [MULT_LAT-1:0][BR_MASK_W-1:0] mask_s;
    logic [MULT_LAT-1:0]                squash_hit_s;
    BRANCH_MASK                         keep_s;

    assign keep_s = resolve_en ? ~resolve_mask : {BR_MASK_W{1'b1}};

    // Flag claims owned by the mispredicted branch, judged on current contents.
    always_comb begin
        squash_hit_s = {MULT_LAT{1'b0}};
        for (int k = 0; k < MULT_LAT; k++) begin
            squash_hit_s[k] = squash_en & (|(mask_r[k] & squash_mask));
        end
    end

    // Advance all claims one slot, drop squashed ones, strip resolved bits, add new claim.
    always_comb begin
        rsv_s  = {MULT_LAT{1'b0}};
        mask_s = {(MULT_LAT*BR_MASK_W){1'b0}};
        for (int k = 0; k < MULT_LAT - 1; k++) begin
            rsv_s[k] = rsv_r[k+1] & ~squash_hit_s[k+1];
            if (rsv_s[k]) begin
                mask_s[k] = mask_r[k+1] & keep_s;
            end else begin
                mask_s[k] = {BR_MASK_W{1'b0}};
            end
        end
        // A grant this cycle lands on the CDB MULT_LAT-1 cycles after the edge.
        if (claim_en) begin
            rsv_s[MULT_LAT-2]  = 1'b1;
            mask_s[MULT_LAT-2] = claim_mask;
        end else begin
            rsv_s[MULT_LAT-2]  = rsv_s[MULT_LAT-2];
            mask_s[MULT_LAT-2] = mask_s[MULT_LAT-2];
        end
    end

    // Claim and mask storage with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rsv_r  <= {MULT_LAT{1'b0}};
            mask_r <= {(MULT_LAT*BR_MASK_W){1'b0}};
        end else begin
            rsv_r  <= rsv_s;
            mask_r <= mask_s;
        end
    end

    assign rsv       = rsv_r;
    assign rsv_first = rsv_r[0];
    assign rsv_last  = rsv_r[MULT_LAT-1];

endmodule

// File: rtl/rs_issue_sched.sv
// Issue scheduler: grants at most one ready RS entry per cycle to the ALU or
// the pipelined multiplier while keeping the single CDB collision-free.
// Build option ISSUE_SCHED_RR_EN: round-robin arbitration from a rotating
// pointer; when undefined, the lowest eligible index always wins.
module rs_issue_sched
    import rs_issue_sched_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic [RS_SIZE-1:0]           req_vec,
    input  logic [RS_SIZE-1:0]           req_is_mult,
    input  logic [RS_SIZE*BR_MASK_W-1:0] req_br_mask,
    input  logic                         fu_stall,
    input  logic                         squash_en,
    input  logic [BR_MASK_W-1:0]         squash_mask,
    input  logic                         resolve_en,
    input  logic [BR_MASK_W-1:0]         resolve_mask,
    output logic [RS_SIZE-1:0]           grant,
    output logic                         grant_valid,
    output logic [RS_IDX_W-1:0]          grant_idx,
    output logic                         grant_is_mult,
    output logic [MULT_LAT-1:0]          cdb_rsv
);

    logic [RS_SIZE-1:0][BR_MASK_W-1:0] entry_mask_s;
    rs_vec_t                           eligible_s;
    rs_vec_t                           grant_s;
    RS_IDX                             grant_idx_s;
    RS_IDX                             start_s;
    logic                              grant_valid_s;
    logic                              grant_mult_s;
    BRANCH_MASK                        claim_mask_s;
    logic [MULT_LAT-1:0]               rsv_vec_s;
    logic                              rsv_first_s;
    logic                              rsv_last_s;

    assign entry_mask_s = req_br_mask;

    // An entry may issue only if its CDB slot is free, it is not being squashed,
    // the FUs can accept it and the block is out of reset.
    always_comb begin
        eligible_s = {RS_SIZE{1'b0}};
        for (int i = 0; i < RS_SIZE; i++) begin
            eligible_s[i] = req_vec[i]
                          & (req_is_mult[i] ? ~rsv_last_s : ~rsv_first_s)
                          & ~(squash_en & (|(entry_mask_s[i] & squash_mask)))
                          & ~fu_stall
                          & reset;
        end
    end

    // Arbitrate and derive index, target unit and claim mask of the winner.
    always_comb begin
        grant_s       = pselect(eligible_s, start_s);
        grant_idx_s   = onehot_to_binary(grant_s);
        grant_valid_s = |grant_s;
        grant_mult_s  = |(grant_s & req_is_mult);
        claim_mask_s  = {BR_MASK_W{1'b0}};
        for (int i = 0; i < RS_SIZE; i++) begin
            if (grant_s[i]) begin
                claim_mask_s = claim_mask_s | entry_mask_s[i];
            end else begin
                claim_mask_s = claim_mask_s;
            end
        end
    end

`ifdef ISSUE_SCHED_RR_EN
    RS_IDX rr_ptr_r;

    // Rotate the search start to just past the last winner; hold when idle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_r <= {RS_IDX_W{1'b0}};
        end else if (grant_valid_s) begin
            if (grant_idx_s == RS_IDX'(RS_SIZE - 1)) begin
                rr_ptr_r <= {RS_IDX_W{1'b0}};
            end else begin
                rr_ptr_r <= grant_idx_s + RS_IDX'(1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign start_s = rr_ptr_r;
`else
    assign start_s = {RS_IDX_W{1'b0}};
`endif

    cdb_slot_tracker u_tracker (
        .clock        (clock),
        .reset        (reset),
        .claim_en     (grant_mult_s),
        .claim_mask   (claim_mask_s),
        .squash_en    (squash_en),
        .squash_mask  (squash_mask),
        .resolve_en   (resolve_en),
        .resolve_mask (resolve_mask),
        .rsv          (rsv_vec_s),
        .rsv_first    (rsv_first_s),
        .rsv_last     (rsv_last_s)
    );

    assign grant         = grant_s;
    assign grant_valid   = grant_valid_s;
    assign grant_idx     = grant_idx_s;
    assign grant_is_mult = grant_mult_s;
    // Reset forces every output low, including stale claims still in storage.
    assign cdb_rsv       = reset ? rsv_vec_s : {MULT_LAT{1'b0}};

endmodule

// File: tb/tb_rs_issue_sched.sv
// Self-checking bench for rs_issue_sched: directed table, hand sequences for
// the CDB-claim corner cases, then random traffic against a reference model
// that tracks claims as absolute CDB cycle numbers.
module tb_rs_issue_sched;
    import rs_issue_sched_pkg::*;

`ifdef ISSUE_SCHED_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif
    localparam int PW = RS_SIZE + 1 + RS_IDX_W + 1 + MULT_LAT;

    logic                         clock;
    logic                         reset;
    logic [RS_SIZE-1:0]           req_vec;
    logic [RS_SIZE-1:0]           req_is_mult;
    logic [RS_SIZE*BR_MASK_W-1:0] req_br_mask;
    logic                         fu_stall;
    logic                         squash_en;
    logic [BR_MASK_W-1:0]         squash_mask;
    logic                         resolve_en;
    logic [BR_MASK_W-1:0]         resolve_mask;
    logic [RS_SIZE-1:0]           grant;
    logic                         grant_valid;
    logic [RS_IDX_W-1:0]          grant_idx;
    logic                         grant_is_mult;
    logic [MULT_LAT-1:0]          cdb_rsv;

    rs_issue_sched dut (
        .clock(clock), .reset(reset), .req_vec(req_vec), .req_is_mult(req_is_mult),
        .req_br_mask(req_br_mask), .fu_stall(fu_stall), .squash_en(squash_en),
        .squash_mask(squash_mask), .resolve_en(resolve_en), .resolve_mask(resolve_mask),
        .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .grant_is_mult(grant_is_mult), .cdb_rsv(cdb_rsv)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: claims keyed by the absolute cycle they use the CDB.
    typedef struct {
        int         due;
        BRANCH_MASK mask;
    } claim_t;
    claim_t claims[$];
    int     cyc  = 0;
    int     rr_m = 0;

    rs_vec_t             exp_grant;
    logic                exp_valid;
    RS_IDX               exp_idx;
    logic                exp_mult;
    logic [MULT_LAT-1:0] exp_rsv;
    logic [PW-1:0]       act_pk;

    task automatic model_eval();
        bit alu_free, mult_free, ok;
        int start, i;
        BRANCH_MASK m;
        exp_grant = '0; exp_valid = 1'b0; exp_idx = '0; exp_mult = 1'b0; exp_rsv = '0;
        if (reset === 1'b1) begin
            alu_free  = 1'b1;
            mult_free = 1'b1;
            foreach (claims[q]) begin
                if (claims[q].due == cyc + 1) alu_free = 1'b0;
                if (claims[q].due == cyc + MULT_LAT) mult_free = 1'b0;
                for (int j = 0; j < MULT_LAT; j++)
                    if (claims[q].due == cyc + j + 1) exp_rsv[j] = 1'b1;
            end
            start = RR_MODE ? rr_m : 0;
            for (int k = 0; k < RS_SIZE; k++) begin
                i  = (start + k) % RS_SIZE;
                m  = req_br_mask[i*BR_MASK_W +: BR_MASK_W];
                ok = req_vec[i] && !fu_stall && (req_is_mult[i] ? mult_free : alu_free)
                     && !(squash_en && ((m & squash_mask) != '0));
                if (ok && !exp_valid) begin
                    exp_valid    = 1'b1;
                    exp_idx      = RS_IDX'(i);
                    exp_mult     = req_is_mult[i];
                    exp_grant[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_update();
        claim_t keep[$];
        claim_t c;
        if (reset !== 1'b1) begin
            claims.delete();
            rr_m = 0;
        end else begin
            foreach (claims[q]) begin
                c = claims[q];
                if (!(squash_en && ((c.mask & squash_mask) != '0))) begin
                    if (resolve_en) c.mask = c.mask & ~resolve_mask;
                    if (c.due > cyc + 1) keep.push_back(c);
                end
            end
            if (exp_valid && exp_mult) begin
                c.due  = cyc + MULT_LAT;
                c.mask = req_br_mask[int'(exp_idx)*BR_MASK_W +: BR_MASK_W];
                keep.push_back(c);
            end
            claims = keep;
            if (exp_valid) rr_m = (int'(exp_idx) + 1) % RS_SIZE;
        end
        cyc++;
    endtask

    task automatic cmp(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {grant,valid,idx,mult,rsv}=%h required %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // One clock: sample at negedge, compare to model, then advance the model.
    task automatic step();
        @(negedge clock);
        model_eval();
        act_pk = {grant, grant_valid, grant_idx, grant_is_mult, cdb_rsv};
        cmp("model", act_pk, {exp_grant, exp_valid, exp_idx, exp_mult, exp_rsv});
        @(posedge clock);
        #1;
        model_update();
    endtask

    task automatic check(input string name, input logic v, input int idx,
                         input logic m, input logic [MULT_LAT-1:0] rsv);
        rs_vec_t g;
        g = v ? (rs_vec_t'(1) << idx) : '0;
        cmp(name, act_pk, {g, v, RS_IDX'(idx), m, rsv});
    endtask

    task automatic idle_inputs();
        reset = 1'b1; req_vec = '0; req_is_mult = '0; req_br_mask = '0;
        fu_stall = 1'b0; squash_en = 1'b0; squash_mask = '0;
        resolve_en = 1'b0; resolve_mask = '0;
    endtask

    task automatic mult_req(input int e, input BRANCH_MASK m);
        req_vec = '0; req_is_mult = '0; req_br_mask = '0;
        req_vec[e] = 1'b1; req_is_mult[e] = 1'b1;
        req_br_mask[e*BR_MASK_W +: BR_MASK_W] = m;
    endtask

    typedef struct {
        logic                rst;
        logic [RS_SIZE-1:0]  req;
        logic [RS_SIZE-1:0]  mult;
        logic                stall;
        logic                v;
        int                  idx_rr;
        int                  idx_fp;
        logic                m;
        logic [MULT_LAT-1:0] rsv;
    } vec_t;
    vec_t tbl[21];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        tbl[0]  = '{1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0,  0,  0, 1'b0, 4'b0000};
        tbl[1]  = '{1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0,  0,  0, 1'b0, 4'b0000};
        tbl[2]  = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1,  0,  0, 1'b0, 4'b0000};
        tbl[3]  = '{1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0,  0,  0, 1'b0, 4'b0000};
        tbl[4]  = '{1'b1, 16'h0003, 16'h0000, 1'b0, 1'b1,  0,  0, 1'b0, 4'b0000};
        tbl[5]  = '{1'b1, 16'h0003, 16'h0000, 1'b0, 1'b1,  1,  0, 1'b0, 4'b0000};
        tbl[6]  = '{1'b1, 16'h0003, 16'h0000, 1'b0, 1'b1,  0,  0, 1'b0, 4'b0000};
        tbl[7]  = '{1'b1, 16'h0003, 16'h0000, 1'b0, 1'b1,  1,  0, 1'b0, 4'b0000};
        tbl[8]  = '{1'b1, 16'h00FF, 16'h0000, 1'b1, 1'b0,  0,  0, 1'b0, 4'b0000};
        tbl[9]  = '{1'b1, 16'h00FF, 16'h0000, 1'b1, 1'b0,  0,  0, 1'b0, 4'b0000};
        tbl[10] = '{1'b1, 16'h00FF, 16'h0000, 1'b1, 1'b0,  0,  0, 1'b0, 4'b0000};
        tbl[11] = '{1'b1, 16'h00FF, 16'h0000, 1'b0, 1'b1,  2,  0, 1'b0, 4'b0000};
        tbl[12] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0,  0,  0, 1'b0, 4'b0000};
        tbl[13] = '{1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 15, 15, 1'b0, 4'b0000};
        tbl[14] = '{1'b1, 16'h8001, 16'h0000, 1'b0, 1'b1,  0,  0, 1'b0, 4'b0000};
        tbl[15] = '{1'b1, 16'h8001, 16'h0000, 1'b0, 1'b1, 15,  0, 1'b0, 4'b0000};
        tbl[16] = '{1'b1, 16'h0004, 16'h0004, 1'b0, 1'b1,  2,  2, 1'b1, 4'b0000};
        tbl[17] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0,  0,  0, 1'b0, 4'b0100};
        tbl[18] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0,  0,  0, 1'b0, 4'b0010};
        tbl[19] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0,  0,  0, 1'b0, 4'b0001};
        tbl[20] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0,  0,  0, 1'b0, 4'b0000};

        idle_inputs();
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Directed table: reset, arbitration order, stall hold, wrap, one claim.
        for (int n = 0; n < 21; n++) begin
            idle_inputs();
            reset = tbl[n].rst; req_vec = tbl[n].req; req_is_mult = tbl[n].mult;
            fu_stall = tbl[n].stall;
            step();
            check($sformatf("vec%0d", n), tbl[n].v,
                  RR_MODE ? tbl[n].idx_rr : tbl[n].idx_fp, tbl[n].m, tbl[n].rsv);
        end

        // MULT on entry 2, ALU on entry 5 blocked only at t+MULT_LAT-1.
        idle_inputs(); reset = 1'b0; step();
        idle_inputs(); mult_req(2, 4'b0000); step(); check("mul_t0", 1'b1, 2, 1'b1, 4'b0000);
        idle_inputs(); req_vec = 16'h0020; step(); check("alu_t1", 1'b1, 5, 1'b0, 4'b0100);
        step(); check("alu_t2", 1'b1, 5, 1'b0, 4'b0010);
        step(); check("alu_t3_blocked", 1'b0, 0, 1'b0, 4'b0001);
        step(); check("alu_t4", 1'b1, 5, 1'b0, 4'b0000);

        // Back-to-back MULTs on entries 1 and 3: adjacent claims shifting down.
        idle_inputs(); mult_req(1, 4'b0000); step(); check("b2b_1", 1'b1, 1, 1'b1, 4'b0000);
        idle_inputs(); mult_req(3, 4'b0000); step(); check("b2b_3", 1'b1, 3, 1'b1, 4'b0100);
        idle_inputs(); step(); check("b2b_sh0", 1'b0, 0, 1'b0, 4'b0110);
        step(); check("b2b_sh1", 1'b0, 0, 1'b0, 4'b0011);
        step(); check("b2b_sh2", 1'b0, 0, 1'b0, 4'b0001);
        step(); check("b2b_sh3", 1'b0, 0, 1'b0, 4'b0000);

        // Squash drops the claim; squashed request is ineligible; ALU then free.
        idle_inputs(); mult_req(2, 4'b0100); step(); check("sq_grant", 1'b1, 2, 1'b1, 4'b0000);
        squash_en = 1'b1; squash_mask = 4'b0100;
        step(); check("sq_cycle", 1'b0, 0, 1'b0, 4'b0100);
        idle_inputs(); step(); check("sq_cleared", 1'b0, 0, 1'b0, 4'b0000);
        req_vec = 16'h0020; step(); check("sq_alu_free", 1'b1, 5, 1'b0, 4'b0000);

        // Squash and resolve on the same bit: squash wins.
        idle_inputs(); mult_req(2, 4'b0010); step(); check("sr_grant", 1'b1, 2, 1'b1, 4'b0000);
        idle_inputs(); squash_en = 1'b1; squash_mask = 4'b0010;
        resolve_en = 1'b1; resolve_mask = 4'b0010;
        step(); check("sr_cycle", 1'b0, 0, 1'b0, 4'b0100);
        idle_inputs(); step(); check("sr_cleared", 1'b0, 0, 1'b0, 4'b0000);

        // Resolve first, later squash of the same bit leaves the claim alone.
        idle_inputs(); mult_req(2, 4'b0010); step(); check("rs_grant", 1'b1, 2, 1'b1, 4'b0000);
        idle_inputs(); resolve_en = 1'b1; resolve_mask = 4'b0010;
        step(); check("rs_resolve", 1'b0, 0, 1'b0, 4'b0100);
        idle_inputs(); squash_en = 1'b1; squash_mask = 4'b0010;
        step(); check("rs_squash", 1'b0, 0, 1'b0, 4'b0010);
        idle_inputs(); step(); check("rs_kept", 1'b0, 0, 1'b0, 4'b0001);

        // Reset while a claim is in flight discards it and forces outputs low.
        idle_inputs(); mult_req(2, 4'b0000); step(); check("rst_grant", 1'b1, 2, 1'b1, 4'b0000);
        idle_inputs(); reset = 1'b0; req_vec = 16'hFFFF; req_is_mult = 16'h00F0;
        step(); check("rst_forced", 1'b0, 0, 1'b0, 4'b0000);
        idle_inputs(); step(); check("rst_discard", 1'b0, 0, 1'b0, 4'b0000);

        // Random traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            r            = $urandom;
            reset        = ($urandom_range(0, 63) != 0);
            req_vec      = r[15:0] & r[31:16];
            r            = $urandom;
            req_is_mult  = r[15:0] | r[31:16];
            for (int e = 0; e < RS_SIZE; e++) begin
                r = 32'($urandom_range(0, 4));
                req_br_mask[e*BR_MASK_W +: BR_MASK_W] = (r == 32'd4) ? 4'b0000 : 4'(1 << r);
            end
            fu_stall     = ($urandom_range(0, 7) == 0);
            squash_en    = ($urandom_range(0, 5) == 0);
            squash_mask  = 4'(1 << $urandom_range(0, 3));
            resolve_en   = ($urandom_range(0, 4) == 0);
            resolve_mask = ($urandom_range(0, 1) == 0) ? squash_mask : 4'(1 << $urandom_range(0, 3));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
